// File: rtl/rr_mux_arbiter_4.sv
// rr_mux_arbiter_4: round-robin arbiter sharing one registered valid/ready output
// channel between four valid/ready requesters.
module rr_mux_arbiter_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_id,
    input  logic             out_ready
);
    logic [1:0]       ptr;
    logic [1:0]       w;
    logic             found;
    logic             load_en;
    logic [WIDTH-1:0] sel_data;

    assign load_en = !out_valid || out_ready;

    // Walk from the farthest slot back to ptr so the nearest valid requester wins.
    always_comb begin
        found = 1'b0;
        w = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (in_valid[ptr + 2'(k)]) begin
                found = 1'b1;
                w = ptr + 2'(k);
            end
        end
    end

    always_comb begin
        sel_data = w == 2'd0 ? in_data0 :
                   w == 2'd1 ? in_data1 :
                   w == 2'd2 ? in_data2 : in_data3;
    end

    assign in_ready = (rst_n && found && load_en) ? 4'b0001 << w : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= 2'd0;
            ptr       <= 2'd0;
        end else if (load_en) begin
            out_valid <= found;
            if (found) begin
                out_data <= sel_data;
                out_id   <= w;
                ptr      <= w + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// tb_rr_mux_arbiter_4: directed vectors with a scoreboard; stimulus queues the
// expected handshakes and words, a negedge monitor pops and compares them.
module tb_rr_mux_arbiter_4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_valid = 4'b0000;
    logic [3:0] d [4];
    logic [3:0] in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] out_id;
    logic       out_ready = 1'b0;

    typedef struct packed {
        logic [3:0] ir;
        logic       ov;
    } cyc_t;
    typedef struct packed {
        logic [1:0] id;
        logic [3:0] data;
    } word_t;

    cyc_t  cq [$];
    word_t wq [$];
    int    total = 0;
    int    bad = 0;

    rr_mux_arbiter_4 #(.WIDTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data0(d[0]),
        .in_data1(d[1]),
        .in_data2(d[2]),
        .in_data3(d[3]),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_id(out_id),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle and queue the hand-computed handshake and any accepted word.
    task automatic step(input logic [3:0] v, input logic r, input logic [3:0] exp_ir, input logic exp_ov);
        word_t wd;
        @(posedge clk);
        #1;
        in_valid = v;
        out_ready = r;
        cq.push_back('{ir: exp_ir, ov: exp_ov});
        for (int i = 0; i < 4; i++) begin
            if (exp_ir[i]) begin
                wd.id = 2'(i);
                wd.data = d[i];
                wq.push_back(wd);
            end
        end
    endtask

    always @(negedge clk) begin
        cyc_t  c;
        word_t wd;
        if (rst_n) begin
            chk("in_ready_onehot0", {7'd0, $onehot0(in_ready)}, 8'd1);
            if (cq.size() > 0) begin
                c = cq.pop_front();
                chk("in_ready", {4'd0, in_ready}, {4'd0, c.ir});
                chk("out_valid", {7'd0, out_valid}, {7'd0, c.ov});
            end
            if (out_valid && out_ready) begin
                if (wq.size() == 0) begin
                    chk("unexpected_word", 8'd1, 8'd0);
                end else begin
                    wd = wq.pop_front();
                    chk("out_id", {6'd0, out_id}, {6'd0, wd.id});
                    chk("out_data", {4'd0, out_data}, {4'd0, wd.data});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        d[0] = 4'hA; d[1] = 4'hB; d[2] = 4'hC; d[3] = 4'hD;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_out_data", {4'd0, out_data}, 8'd0);
        chk("rst_out_id", {6'd0, out_id}, 8'd0);
        chk("rst_in_ready", {4'd0, in_ready}, 8'd0);
        in_valid = 4'b0000;
        @(negedge clk);
        #2 rst_n = 1'b1;

        // rotation 0,1,2,3,0
        step(4'b1111, 1'b1, 4'b0001, 1'b0);
        step(4'b1111, 1'b1, 4'b0010, 1'b1);
        step(4'b1111, 1'b1, 4'b0100, 1'b1);
        step(4'b1111, 1'b1, 4'b1000, 1'b1);
        step(4'b1111, 1'b1, 4'b0001, 1'b1);
        // ptr=1: 1001 grants 3 then 0, then output empties
        step(4'b1001, 1'b1, 4'b1000, 1'b1);
        step(4'b0001, 1'b1, 4'b0001, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 1'b0);

        // backpressure: word 5 held for three stalled cycles, then data1 follows
        d[2] = 4'h5; d[1] = 4'h9;
        step(4'b0100, 1'b1, 4'b0100, 1'b0);
        step(4'b0010, 1'b0, 4'b0000, 1'b1);
        step(4'b0010, 1'b0, 4'b0000, 1'b1);
        step(4'b0010, 1'b0, 4'b0000, 1'b1);
        step(4'b0010, 1'b1, 4'b0010, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 1'b0);

        // idle bubble: single-cycle request from 2
        d[2] = 4'h7;
        step(4'b0100, 1'b1, 4'b0100, 1'b0);
        step(4'b0000, 1'b1, 4'b0000, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 1'b0);

        // load a word from 0 (ptr becomes 1), stall it, then reset asynchronously
        step(4'b0001, 1'b0, 4'b0001, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_rst_out_valid", {7'd0, out_valid}, 8'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("async_rst_out_data", {4'd0, out_data}, 8'd0);
        chk("async_rst_out_id", {6'd0, out_id}, 8'd0);
        chk("async_rst_in_ready", {4'd0, in_ready}, 8'd0);
        wq.delete();
        cq.delete();
        in_valid = 4'b0000;
        @(negedge clk);
        #2 rst_n = 1'b1;

        // ptr back at 0: 1001 grants 0 first, then 3
        step(4'b1001, 1'b1, 4'b0001, 1'b0);
        step(4'b1000, 1'b1, 4'b1000, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("words_left", 8'(wq.size()), 8'd0);
        chk("cycles_left", 8'(cq.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
